// File: rtl/cache_pkg.sv
// Shared state encoding and geometry helpers for the direct-mapped data cache.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WRITE
   } cache_state_t;

   function automatic int idx_w(input int nlines);
      return (nlines > 1) ? $clog2(nlines) : 1;
   endfunction

   function automatic int tag_w(input int nbits, input int nlines);
      return nbits - idx_w(nlines);
   endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for the data cache: async read, one write port,
// valid bits cleared by reset while tag and data are left untouched.
module cache_line_array
   import cache_pkg::*;
#(
   parameter int NBITS  = 8,
   parameter int NLINES = 4,
   localparam int IDXW  = idx_w(NLINES),
   localparam int TAGW  = tag_w(NBITS, NLINES)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [IDXW-1:0]  rd_idx_i,
   output logic             rd_valid_o,
   output logic [TAGW-1:0]  rd_tag_o,
   output logic [NBITS-1:0] rd_data_o,
   input  logic             we_i,
   input  logic [IDXW-1:0]  wr_idx_i,
   input  logic [TAGW-1:0]  wr_tag_i,
   input  logic [NBITS-1:0] wr_data_i
);

   logic [NLINES-1:0] valid_q;
   logic [TAGW-1:0]   tag_q  [NLINES];
   logic [NBITS-1:0]  data_q [NLINES];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (we_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a
// req/ack backing-memory port and a combinational busy stall.
module data_cache
   import cache_pkg::*;
#(
   parameter int NBITS  = 8,
   parameter int NLINES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [NBITS-1:0] addr,
   input  logic [NBITS-1:0] wdata,
   input  logic             MemRead,
   input  logic             MemWrite,
   output logic [NBITS-1:0] rdata,
   output logic             busy,
   output logic [NBITS-1:0] mem_addr,
   output logic [NBITS-1:0] mem_wdata,
   output logic             mem_req,
   output logic             mem_we,
   input  logic [NBITS-1:0] mem_rdata,
   input  logic             mem_ack
);

   localparam int IDXW = idx_w(NLINES);
   localparam int TAGW = tag_w(NBITS, NLINES);

   cache_state_t     state_q;
   logic [NBITS-1:0] addr_q;
   logic [NBITS-1:0] wdata_q;
   logic             one_shot_q;

   logic [NBITS-1:0] lk_addr;
   logic             lk_valid;
   logic [TAGW-1:0]  lk_tag;
   logic [NBITS-1:0] lk_data;
   logic             hit;
   logic             wr_go;
   logic             rd_miss;
   logic             line_we;
   logic [NBITS-1:0] fill_data;

   // In IDLE look up the live address; while busy, the latched one.
   assign lk_addr   = (state_q == IDLE) ? addr : addr_q;
   assign hit       = lk_valid && (lk_tag == lk_addr[NBITS-1:IDXW]);
   assign wr_go     = MemWrite && !one_shot_q;
   assign rd_miss   = !MemWrite && MemRead && !hit;
   assign line_we   = mem_ack
                    && ((state_q == FETCH) || ((state_q == WRITE) && hit));
   assign fill_data = (state_q == WRITE) ? wdata_q : mem_rdata;

   cache_line_array #(
      .NBITS  (NBITS),
      .NLINES (NLINES)
   ) u_lines (
      .clock      (clock),
      .reset      (reset),
      .rd_idx_i   (lk_addr[IDXW-1:0]),
      .rd_valid_o (lk_valid),
      .rd_tag_o   (lk_tag),
      .rd_data_o  (lk_data),
      .we_i       (line_we),
      .wr_idx_i   (addr_q[IDXW-1:0]),
      .wr_tag_i   (addr_q[NBITS-1:IDXW]),
      .wr_data_i  (fill_data)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         one_shot_q <= 1'b0;
      end else begin
         one_shot_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (wr_go) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  state_q <= WRITE;
               end else if (rd_miss) begin
                  addr_q  <= addr;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               if (mem_ack) state_q <= IDLE;
            end
            WRITE: begin
               if (mem_ack) begin
                  state_q    <= IDLE;
                  one_shot_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A store held over into the one-shot cycle still stalls but is not reissued.
   always_comb begin
      busy  = 1'b0;
      rdata = '0;
      if (reset) begin
         busy = (state_q != IDLE) || MemWrite || rd_miss;
         if ((state_q == IDLE) && !MemWrite && MemRead && hit) begin
            rdata = lk_data;
         end
      end
   end

   assign mem_req   = reset && (state_q != IDLE);
   assign mem_we    = reset && (state_q == WRITE);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed table, reset corners and
// randomized traffic against a line/memory reference model.
module tb_data_cache;

   localparam int NL = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] addr, wdata, rdata;
   logic       MemRead, MemWrite, busy;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_req, mem_we, mem_ack;

   data_cache #(.NBITS(8), .NLINES(NL)) dut (
      .clock     (clock),
      .reset     (reset),
      .addr      (addr),
      .wdata     (wdata),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .rdata     (rdata),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit         rd;
      bit         wr;
      logic [7:0] a;
      logic [7:0] d;
      int         lat;
      bit         b0;
      logic [7:0] rv;
      int         nrd;
      int         nwr;
   } vec_t;

   vec_t       tbl [15];
   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] bmem [256];
   logic [7:0] ref_mem [256];
   bit         mv [NL];
   int         mt [NL];
   int         hs_rd = 0;
   int         hs_wr = 0;
   int         ack_lat = 3;
   int         wt = 0;
   logic [7:0] last_a, last_d, cap_a, cap_d;
   logic       last_we, cap_we;
   bit         unstable;

   task automatic chk(input string n, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", n, got, exp);
      end
   endtask

   // Backing memory: acks after ack_lat waiting cycles, checks request stability.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clock);
         #1;
         if (!reset) begin
            mem_ack = 1'b0;
            wt = 0;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
            wt = 0;
         end else if (mem_req) begin
            if (wt == 0) begin
               cap_a = mem_addr;
               cap_d = mem_wdata;
               cap_we = mem_we;
               unstable = 1'b0;
            end else if (mem_addr !== cap_a || mem_we !== cap_we
                         || (cap_we && mem_wdata !== cap_d)) begin
               unstable = 1'b1;
            end
            if (wt >= ack_lat) begin
               mem_ack = 1'b1;
               mem_rdata = bmem[mem_addr];
               if (mem_we) begin
                  bmem[mem_addr] = mem_wdata;
                  hs_wr++;
               end else begin
                  hs_rd++;
               end
               last_a = mem_addr;
               last_d = mem_wdata;
               last_we = mem_we;
               chk("req_stable", 32'(unstable), 32'd0);
            end else begin
               wt++;
            end
         end else begin
            wt = 0;
         end
      end
   end

   task automatic model(input bit rd, input bit wr, input logic [7:0] a,
                        input logic [7:0] d, output bit e_b0,
                        output logic [7:0] e_rv, output int e_nrd,
                        output int e_nwr);
      int  i, t;
      bit  h;
      i = int'(a) % NL;
      t = int'(a) / NL;
      h = mv[i] && (mt[i] == t);
      e_rv = '0;
      e_nrd = 0;
      e_nwr = 0;
      e_b0 = 1'b0;
      if (wr) begin
         e_b0 = 1'b1;
         e_nwr = 1;
         ref_mem[a] = d;
      end else if (rd) begin
         e_b0 = !h;
         e_nrd = h ? 0 : 1;
         e_rv = ref_mem[a];
         mv[i] = 1'b1;
         mt[i] = t;
      end
   endtask

   task automatic do_access(input bit rd, input bit wr, input logic [7:0] a,
                            input logic [7:0] d, output bit b0,
                            output logic [7:0] rv, output int nr,
                            output int nw, output bit ok);
      int r0, w0;
      r0 = hs_rd;
      w0 = hs_wr;
      rv = '0;
      ok = 1'b0;
      @(posedge clock);
      #2;
      MemRead = rd;
      MemWrite = wr;
      addr = a;
      wdata = d;
      #1 b0 = busy;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clock);
         if (wr) begin
            ok = mem_ack;
         end else if (!busy) begin
            ok = 1'b1;
            rv = rdata;
         end
      end
      if (wr && ok) begin
         @(negedge clock);
         chk("oneshot_no_req", 32'(mem_req), 32'd0);
      end
      @(posedge clock);
      #2;
      MemRead = 1'b0;
      MemWrite = 1'b0;
      @(negedge clock);
      chk("idle_after", 32'({busy, mem_req, rdata}), 32'd0);
      nr = hs_rd - r0;
      nw = hs_wr - w0;
   endtask

   task automatic run_vec(input string n, input bit rd, input bit wr,
                          input logic [7:0] a, input logic [7:0] d,
                          input bit e_b0, input logic [7:0] e_rv,
                          input int e_nrd, input int e_nwr);
      bit         b0, ok;
      logic [7:0] rv;
      int         nr, nw;
      do_access(rd, wr, a, d, b0, rv, nr, nw, ok);
      chk({n, " done"}, 32'(ok), 32'd1);
      chk({n, " busy0"}, 32'(b0), 32'(e_b0));
      chk({n, " nrd"}, 32'(nr), 32'(e_nrd));
      chk({n, " nwr"}, 32'(nw), 32'(e_nwr));
      if (rd && !wr) chk({n, " rdata"}, 32'(rv), 32'(e_rv));
      if (e_nrd + e_nwr > 0) begin
         chk({n, " mem_addr"}, 32'(last_a), 32'(a));
         chk({n, " mem_we"}, 32'(last_we), 32'(wr));
         if (wr) chk({n, " mem_wdata"}, 32'(last_d), 32'(d));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit         e_b0, ok, rd, wr;
      logic [7:0] e_rv, a, d;
      int         e_nrd, e_nwr, op;

      reset = 1'b1;
      MemRead = 1'b0;
      MemWrite = 1'b0;
      addr = '0;
      wdata = '0;
      for (int i = 0; i < 256; i++) bmem[i] = 8'($urandom);
      bmem[8'h05] = 8'hA7;
      bmem[8'h09] = 8'h3C;
      bmem[8'hFF] = 8'h9E;
      bmem[8'h00] = 8'h5A;
      bmem[8'h04] = 8'hC3;
      for (int i = 0; i < 256; i++) ref_mem[i] = bmem[i];
      for (int i = 0; i < NL; i++) mv[i] = 1'b0;

      tbl[0]  = '{1'b1, 1'b0, 8'h05, 8'h00, 3, 1'b1, 8'hA7, 1, 0};
      tbl[1]  = '{1'b1, 1'b0, 8'h05, 8'h00, 3, 1'b0, 8'hA7, 0, 0};
      tbl[2]  = '{1'b1, 1'b0, 8'h09, 8'h00, 2, 1'b1, 8'h3C, 1, 0};
      tbl[3]  = '{1'b1, 1'b0, 8'h05, 8'h00, 1, 1'b1, 8'hA7, 1, 0};
      tbl[4]  = '{1'b0, 1'b1, 8'h05, 8'h11, 2, 1'b1, 8'h00, 0, 1};
      tbl[5]  = '{1'b1, 1'b0, 8'h05, 8'h00, 1, 1'b0, 8'h11, 0, 0};
      tbl[6]  = '{1'b0, 1'b1, 8'h06, 8'h22, 0, 1'b1, 8'h00, 0, 1};
      tbl[7]  = '{1'b1, 1'b0, 8'h06, 8'h00, 1, 1'b1, 8'h22, 1, 0};
      tbl[8]  = '{1'b1, 1'b1, 8'h07, 8'h55, 3, 1'b1, 8'h00, 0, 1};
      tbl[9]  = '{1'b1, 1'b0, 8'h07, 8'h00, 0, 1'b1, 8'h55, 1, 0};
      tbl[10] = '{1'b1, 1'b0, 8'hFF, 8'h00, 2, 1'b1, 8'h9E, 1, 0};
      tbl[11] = '{1'b1, 1'b0, 8'hFF, 8'h00, 2, 1'b0, 8'h9E, 0, 0};
      tbl[12] = '{1'b1, 1'b0, 8'h00, 8'h00, 1, 1'b1, 8'h5A, 1, 0};
      tbl[13] = '{1'b1, 1'b0, 8'h04, 8'h00, 1, 1'b1, 8'hC3, 1, 0};
      tbl[14] = '{1'b1, 1'b0, 8'h00, 8'h00, 1, 1'b1, 8'h5A, 1, 0};

      #1 reset = 1'b0;
      repeat (2) @(posedge clock);
      #2;
      MemRead = 1'b1;
      MemWrite = 1'b1;
      addr = 8'h05;
      #1 chk("in_reset", 32'({busy, mem_req, mem_we, rdata}), 32'd0);
      MemRead = 1'b0;
      MemWrite = 1'b0;
      @(posedge clock);
      #2 reset = 1'b1;

      ack_lat = 20;
      @(posedge clock);
      #2;
      MemRead = 1'b1;
      addr = 8'h05;
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clock);
         ok = mem_req;
      end
      chk("fetch_started", 32'(ok), 32'd1);
      #1 reset = 1'b0;
      #1 chk("reset_drops_req", 32'({mem_req, busy, mem_we}), 32'd0);
      @(posedge clock);
      #2 reset = 1'b1;
      #1 chk("miss_after_reset", 32'(busy), 32'd1);
      MemRead = 1'b0;
      ack_lat = 3;
      repeat (2) @(posedge clock);
      chk("no_fill_after_reset", 32'(hs_rd + hs_wr), 32'd0);

      for (int i = 0; i < 15; i++) begin
         ack_lat = tbl[i].lat;
         model(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d,
               e_b0, e_rv, e_nrd, e_nwr);
         run_vec($sformatf("t%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].a,
                 tbl[i].d, tbl[i].b0, tbl[i].rv, tbl[i].nrd, tbl[i].nwr);
      end

      for (int k = 0; k < 150; k++) begin
         op = int'($urandom_range(0, 9));
         rd = (op < 6) || (op == 9);
         wr = (op >= 6);
         a = 8'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) a = a | 8'hF0;
         d = 8'($urandom);
         ack_lat = int'($urandom_range(0, 4));
         model(rd, wr, a, d, e_b0, e_rv, e_nrd, e_nwr);
         run_vec($sformatf("rand%0d", k), rd, wr, a, d,
                 e_b0, e_rv, e_nrd, e_nwr);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
